// File: rtl/ae_pkg.sv
// Shared types for the autoencoder address generator: default index width and FSM states.
package ae_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ae_wrap_counter.sv
// Enabled up-counter that wraps to zero after LIMIT-1; wrap flags the wrapping beat.
module ae_wrap_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mac_addr_gen.sv
// Nested-loop index/address generator for the autoencoder MAC datapath.
// Optional epoch counter output enabled by defining AE_ADDR_GEN_EPOCH_EN.
module mac_addr_gen
    import ae_pkg::*;
#(
    parameter int               N_IN   = 8,
    parameter int               N_OUT  = 4,
    parameter int               CNT_W  = CNT_W_DEF,
    parameter logic [CNT_W-1:0] W_BASE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] in_idx,
    output logic [CNT_W-1:0] out_idx,
    output logic [CNT_W-1:0] w_addr,
    output logic             row_first,
    output logic             row_last,
    output logic             busy,
    output logic             done
`ifdef AE_ADDR_GEN_EPOCH_EN
    ,
    output logic [CNT_W-1:0] epoch_cnt
`endif
);

    state_t state;
    logic   beat;
    logic   in_wrap;
    logic   out_wrap;

    // clear overrides a same-cycle handshake, so it also blocks the counters
    assign beat = out_valid && out_ready && !clear;

    ae_wrap_counter #(.W(CNT_W), .LIMIT(N_IN)) u_inner (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (beat),
        .clr   (clear),
        .cnt   (in_idx),
        .wrap  (in_wrap)
    );

    ae_wrap_counter #(.W(CNT_W), .LIMIT(N_OUT)) u_outer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_wrap),
        .clr   (clear),
        .cnt   (out_idx),
        .wrap  (out_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            w_addr    <= '0;
        end else if (clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            w_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        w_addr    <= W_BASE;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (out_wrap) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            w_addr    <= '0;
                        end else begin
                            w_addr <= w_addr + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign row_first = out_valid && (in_idx == '0);
    assign row_last  = out_valid && (in_idx == CNT_W'(N_IN - 1));

`ifdef AE_ADDR_GEN_EPOCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epoch_cnt <= '0;
        end else if (done && (epoch_cnt != '1)) begin
            epoch_cnt <= epoch_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_addr_gen.sv
// Randomized bench for mac_addr_gen: three configurations checked against a beat-list model.
module tb_mac_addr_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int ni[3] = '{8, 2, 1};
    int no[3] = '{4, 2, 1};
    int wb[3] = '{0, 32'hFFFE, 0};

    logic        start_s  [3];
    logic        clear_s  [3];
    logic        ready_s  [3];
    logic        valid_s  [3];
    logic [15:0] in_idx_s [3];
    logic [15:0] out_idx_s[3];
    logic [15:0] w_addr_s [3];
    logic        first_s  [3];
    logic        last_s   [3];
    logic        busy_s   [3];
    logic        done_s   [3];
`ifdef AE_ADDR_GEN_EPOCH_EN
    logic [15:0] epoch_s  [3];
    int          epoch_exp[3] = '{0, 0, 0};
`endif

    int checks = 0;
    int errors = 0;

    mac_addr_gen #(.N_IN(8), .N_OUT(4), .CNT_W(16), .W_BASE(16'h0000)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .clear(clear_s[0]), .out_ready(ready_s[0]),
        .out_valid(valid_s[0]), .in_idx(in_idx_s[0]), .out_idx(out_idx_s[0]), .w_addr(w_addr_s[0]),
        .row_first(first_s[0]), .row_last(last_s[0]), .busy(busy_s[0]), .done(done_s[0])
`ifdef AE_ADDR_GEN_EPOCH_EN
        , .epoch_cnt(epoch_s[0])
`endif
    );

    mac_addr_gen #(.N_IN(2), .N_OUT(2), .CNT_W(16), .W_BASE(16'hFFFE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .clear(clear_s[1]), .out_ready(ready_s[1]),
        .out_valid(valid_s[1]), .in_idx(in_idx_s[1]), .out_idx(out_idx_s[1]), .w_addr(w_addr_s[1]),
        .row_first(first_s[1]), .row_last(last_s[1]), .busy(busy_s[1]), .done(done_s[1])
`ifdef AE_ADDR_GEN_EPOCH_EN
        , .epoch_cnt(epoch_s[1])
`endif
    );

    mac_addr_gen #(.N_IN(1), .N_OUT(1), .CNT_W(16), .W_BASE(16'h0000)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .clear(clear_s[2]), .out_ready(ready_s[2]),
        .out_valid(valid_s[2]), .in_idx(in_idx_s[2]), .out_idx(out_idx_s[2]), .w_addr(w_addr_s[2]),
        .row_first(first_s[2]), .row_last(last_s[2]), .busy(busy_s[2]), .done(done_s[2])
`ifdef AE_ADDR_GEN_EPOCH_EN
        , .epoch_cnt(epoch_s[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int k, input string tag);
        check({tag, ".valid"}, 32'(valid_s[k]), 0);
        check({tag, ".busy"}, 32'(busy_s[k]), 0);
        check({tag, ".done"}, 32'(done_s[k]), 0);
        check({tag, ".in_idx"}, 32'(in_idx_s[k]), 0);
        check({tag, ".out_idx"}, 32'(out_idx_s[k]), 0);
        check({tag, ".w_addr"}, 32'(w_addr_s[k]), 0);
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: random ready
    task automatic run_pass(input int k, input int mode, input bit poke_start);
        int q_i[$];
        int q_o[$];
        int q_a[$];
        int beats = 0;
        int cyc = 0;
        int total;
        bit rdy;
        total = ni[k] * no[k];
        for (int o = 0; o < no[k]; o++)
            for (int i = 0; i < ni[k]; i++) begin
                q_i.push_back(i);
                q_o.push_back(o);
                q_a.push_back((wb[k] + o * ni[k] + i) % 65536);
            end
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        check($sformatf("d%0d.launch_valid", k), 32'(valid_s[k]), 1);
        while (cyc < 2000 && valid_s[k]) begin
            if (q_i.size() == 0) begin
                check($sformatf("d%0d.extra_beat", k), 1, 0);
                break;
            end
            check($sformatf("d%0d.busy", k), 32'(busy_s[k]), 1);
            check($sformatf("d%0d.done_early", k), 32'(done_s[k]), 0);
            check($sformatf("d%0d.in_idx", k), 32'(in_idx_s[k]), 32'(q_i[0]));
            check($sformatf("d%0d.out_idx", k), 32'(out_idx_s[k]), 32'(q_o[0]));
            check($sformatf("d%0d.w_addr", k), 32'(w_addr_s[k]), 32'(q_a[0]));
            check($sformatf("d%0d.row_first", k), 32'(first_s[k]), 32'(q_i[0] == 0));
            check($sformatf("d%0d.row_last", k), 32'(last_s[k]), 32'(q_i[0] == ni[k] - 1));
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            ready_s[k] = rdy;
            if (poke_start) start_s[k] = 1'($urandom_range(0, 1));
            if (rdy) begin
                void'(q_i.pop_front());
                void'(q_o.pop_front());
                void'(q_a.pop_front());
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        ready_s[k] = 1'b0;
        check($sformatf("d%0d.timeout", k), 32'(cyc < 2000), 1);
        check($sformatf("d%0d.beats", k), 32'(beats), 32'(total));
        check($sformatf("d%0d.done_pulse", k), 32'(done_s[k]), 1);
        check($sformatf("d%0d.done_busy", k), 32'(busy_s[k]), 1);
        check($sformatf("d%0d.done_in_idx", k), 32'(in_idx_s[k]), 0);
        check($sformatf("d%0d.done_out_idx", k), 32'(out_idx_s[k]), 0);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        check_idle(k, $sformatf("d%0d.after_done", k));
`ifdef AE_ADDR_GEN_EPOCH_EN
        epoch_exp[k]++;
        check($sformatf("d%0d.epoch", k), 32'(epoch_s[k]), 32'(epoch_exp[k]));
`endif
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            clear_s[k] = 1'b0;
            ready_s[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_idle(k, $sformatf("d%0d.reset", k));
            check($sformatf("d%0d.reset_first", k), 32'(first_s[k]), 0);
`ifdef AE_ADDR_GEN_EPOCH_EN
            check($sformatf("d%0d.reset_epoch", k), 32'(epoch_s[k]), 0);
`endif
        end
        rst_n = 1'b1;

        run_pass(0, 0, 1'b0);
        run_pass(0, 1, 1'b0);

        // abort on the fifth beat while a handshake is also offered
        @(negedge clk);
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("clr.beat5_in_idx", 32'(in_idx_s[0]), 4);
        clear_s[0] = 1'b1;
        @(negedge clk);
        clear_s[0] = 1'b0;
        ready_s[0] = 1'b0;
        check_idle(0, "clr.next");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("clr.no_done", 32'(done_s[0]), 0);
        end

        run_pass(0, 2, 1'b1);
        run_pass(1, 0, 1'b0);
        run_pass(1, 2, 1'b1);
        run_pass(2, 0, 1'b0);
        run_pass(2, 1, 1'b1);

        // asynchronous reset in the middle of a pass
        @(negedge clk);
        start_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.pre_busy", 32'(busy_s[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "rst.async");
`ifdef AE_ADDR_GEN_EPOCH_EN
        for (int k = 0; k < 3; k++) epoch_exp[k] = 0;
        check("rst.epoch", 32'(epoch_s[0]), 0);
`endif
        ready_s[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.no_done", 32'(done_s[0]), 0);

        run_pass(2, 2, 1'b0);
        run_pass(0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
